// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative 32x32 unsigned shift-and-add multiplier with a 64-bit product.
// Each RUN cycle performs one partial-product accumulation through a 32-bit
// adder with carry-out, then shifts {carry, sum, multiplier} right by one.
// Exactly one operation is in flight at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid (and its data) until that edge.
// Ready never depends combinationally on the partner's valid; both in_ready
// and out_valid are decoded from the state register only (in_ready is also
// gated by rst).
//
// Optional feature macro: MUL_EARLY_EXIT_EN
//   When defined, RUN ends as soon as the unconsumed multiplier bits are all
//   zero. The partial result is then re-aligned with a single variable right
//   shift. Product values match the default build.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   in_valid    in   1   operand pair valid
//   in_ready    out  1   block can accept operands (IDLE and not in reset)
//   a           in   32  multiplicand, unsigned
//   b           in   32  multiplier, unsigned
//   out_valid   out  1   product valid (DONE)
//   out_ready   in   1   consumer accepts product
//   product     out  64  a*b, unsigned
//   hi_nonzero  out  1   product[63:32] != 0 (32-bit truncation overflow)
//   dbg_state   out  2   current FSM state: 0 IDLE, 1 RUN, 2 DONE
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        hi_nonzero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_mcand;
    logic [31:0] r_mq;
    logic [31:0] r_p_hi;
    logic [4:0]  r_cnt;
    logic [63:0] r_product;
    logic        r_hi_nonzero;

    logic        w_accept;
    logic        w_handshake_out;
    logic [31:0] w_addend;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [31:0] w_p_hi_next;
    logic [31:0] w_mq_next;
    logic        w_last;
    logic        w_done_step;
    logic [63:0] w_prod_final;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign in_ready        = (r_state == S_IDLE) && !rst;
    assign out_valid       = (r_state == S_DONE);
    assign w_accept        = in_valid && in_ready;
    assign w_handshake_out = out_valid && out_ready;
    assign dbg_state       = r_state;
    assign product         = r_product;
    assign hi_nonzero      = r_hi_nonzero;

    // ------------------------------------------------------------------
    // One accumulation step: {c, s} = p_hi + (mq[0] ? mcand : 0) + cin.
    // The carry is shifted into p_hi[31], so it ends up as product bit 63
    // on the final step rather than being dropped.
    // ------------------------------------------------------------------
    assign w_cin       = 1'b0;
    assign w_addend    = r_mq[0] ? r_mcand : 32'd0;
    assign w_sum       = {1'b0, r_p_hi} + {1'b0, w_addend} + {32'd0, w_cin};
    assign w_p_hi_next = w_sum[32:1];
    assign w_mq_next   = {w_sum[0], r_mq[31:1]};
    assign w_last      = (r_cnt == 5'd31);

`ifdef MUL_EARLY_EXIT_EN
    // At step cnt the remaining multiplier bits b >> (cnt+1) sit in
    // r_mq[31-cnt:1]. When they are all zero, the remaining steps would only
    // shift, so the result is re-aligned by (31-cnt) in one go.
    logic [31:0] w_rem_mask;
    logic        w_rem_zero;
    logic [4:0]  w_align;

    assign w_rem_mask   = 32'hFFFF_FFFF >> ({1'b0, r_cnt} + 6'd1);
    assign w_rem_zero   = (((r_mq >> 1) & w_rem_mask) == 32'd0);
    assign w_align      = 5'd31 - r_cnt;
    assign w_done_step  = w_last || w_rem_zero;
    assign w_prod_final = {w_p_hi_next, w_mq_next} >> w_align;
`else
    assign w_done_step  = w_last;
    assign w_prod_final = {w_p_hi_next, w_mq_next};
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)        w_state_next = S_RUN;
            S_RUN:  if (w_done_step)     w_state_next = S_DONE;
            S_DONE: if (w_handshake_out) w_state_next = S_IDLE;
            default:                     w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand      <= 32'd0;
            r_mq         <= 32'd0;
            r_p_hi       <= 32'd0;
            r_cnt        <= 5'd0;
            r_product    <= 64'd0;
            r_hi_nonzero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand <= a;
                r_mq    <= b;
                r_p_hi  <= 32'd0;
                r_cnt   <= 5'd0;
            end else if (r_state == S_RUN) begin
                r_p_hi <= w_p_hi_next;
                r_mq   <= w_mq_next;
                r_cnt  <= r_cnt + 5'd1;
                // Product is only captured on the final step, so it stays
                // stable throughout DONE regardless of out_ready.
                if (w_done_step) begin
                    r_product    <= w_prod_final;
                    r_hi_nonzero <= |w_prod_final[63:32];
                end
            end
        end
    end

endmodule
